// File: rtl/reg_rename_pkg.sv
// reg_rename_pkg: shared constants and types for the register rename stage.
// Contents: register-file sizes, free-list geometry, physical/architectural register types.
package reg_rename_pkg;
    localparam int NUM_ARCH_REGS   = 32;
    localparam int NUM_PHYS_REGS   = 64;
    localparam int PHYS_ADDR_WIDTH = $clog2(NUM_PHYS_REGS);
    // Free list only ever holds the registers not pinned by the architectural map.
    localparam int FREE_CAP        = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FREE_PTR_WIDTH  = $clog2(FREE_CAP);

    typedef logic [PHYS_ADDR_WIDTH-1:0] phys_reg_t;
    typedef logic [4:0]                 arch_reg_t;
    typedef logic [PHYS_ADDR_WIDTH:0]   free_count_t;
    typedef logic [FREE_PTR_WIDTH-1:0]  free_ptr_t;
endpackage

// File: rtl/reg_rename_if.sv
// reg_rename_if: decoder-side request, renamed-instruction output and commit-free bundle.
// Modports: slave (rename stage) consumes i_* and drives o_*; master is the mirror image.
interface reg_rename_if;
    import reg_rename_pkg::*;
    logic        i_valid;
    logic        o_ready;
    logic        i_uses_rs;
    arch_reg_t   i_rs_addr;
    logic        i_uses_rt;
    arch_reg_t   i_rt_addr;
    logic        i_uses_rw;
    arch_reg_t   i_rw_addr;
    logic        o_valid;
    logic        i_ready;
    logic        o_uses_rs;
    logic        o_uses_rt;
    logic        o_uses_rw;
    phys_reg_t   o_rs_phys;
    phys_reg_t   o_rt_phys;
    phys_reg_t   o_rw_phys;
    phys_reg_t   o_old_rw_phys;
    logic        i_commit_free;
    phys_reg_t   i_commit_phys;
    free_count_t o_free_count;

    modport slave (
        input  i_valid, i_uses_rs, i_rs_addr, i_uses_rt, i_rt_addr, i_uses_rw, i_rw_addr,
               i_ready, i_commit_free, i_commit_phys,
        output o_ready, o_valid, o_uses_rs, o_uses_rt, o_uses_rw, o_rs_phys, o_rt_phys,
               o_rw_phys, o_old_rw_phys, o_free_count
    );
    modport master (
        output i_valid, i_uses_rs, i_rs_addr, i_uses_rt, i_rt_addr, i_uses_rw, i_rw_addr,
               i_ready, i_commit_free, i_commit_phys,
        input  o_ready, o_valid, o_uses_rs, o_uses_rt, o_uses_rw, o_rs_phys, o_rt_phys,
               o_rw_phys, o_old_rw_phys, o_free_count
    );
endinterface

// File: rtl/reg_rename_phys_free_list.sv
// phys_free_list: circular FIFO of free physical registers.
// Ports: clk, rst_n (sync active-low); alloc pops head_phys; free/free_phys push at the tail;
// count is the current occupancy.
module phys_free_list
    import reg_rename_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alloc,
    input  logic        free,
    input  phys_reg_t   free_phys,
    output phys_reg_t   head_phys,
    output free_count_t count
);
    phys_reg_t mem [FREE_CAP];
    free_ptr_t head;
    free_ptr_t tail;
    logic      full;
    logic      push;

    assign full      = count == free_count_t'(FREE_CAP);
    // Phys 0 is the hardwired zero register and never enters the list; overflow frees are dropped.
    assign push      = free && free_phys != '0 && !full;
    assign head_phys = mem[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FREE_CAP; i++) mem[i] <= phys_reg_t'(NUM_ARCH_REGS + i);
            head  <= '0;
            tail  <= '0;
            count <= free_count_t'(FREE_CAP);
        end else begin
            if (push) begin
                mem[tail] <= free_phys;
                tail      <= tail + free_ptr_t'(1);
            end
            if (alloc) head <= head + free_ptr_t'(1);
            count <= count + free_count_t'(push) - free_count_t'(alloc);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(free && free_phys != '0 && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(alloc && count == '0));
endmodule

// File: rtl/reg_rename.sv
// reg_rename: maps architectural sources/destination to physical registers, one instruction per cycle.
// Ports: clk, rst_n (sync active-low); rr (reg_rename_if.slave) carries the decoder request,
// the registered renamed instruction, the commit-free return path and the free-list count.
module reg_rename
    import reg_rename_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    reg_rename_if.slave rr
);
    phys_reg_t   rmt [NUM_ARCH_REGS];
    phys_reg_t   alloc_phys;
    free_count_t free_count;
    logic        fire;
    logic        alloc;

    // Ready ignores the instruction itself, so an empty list stalls even rw-less instructions.
    assign rr.o_ready      = (!rr.o_valid || rr.i_ready) && free_count != '0;
    assign rr.o_free_count = free_count;
    assign fire            = rr.i_valid && rr.o_ready;
    assign alloc           = fire && rr.i_uses_rw && rr.i_rw_addr != '0;

    phys_free_list u_free_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc     (alloc),
        .free      (rr.i_commit_free),
        .free_phys (rr.i_commit_phys),
        .head_phys (alloc_phys),
        .count     (free_count)
    );

    // rmt[0] is never written, which keeps arch reg 0 pinned to phys 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rmt[i] <= phys_reg_t'(i);
        end else if (alloc) begin
            rmt[rr.i_rw_addr] <= alloc_phys;
        end
    end

    // Sources read the map before this instruction's own update lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr.o_valid       <= 1'b0;
            rr.o_uses_rs     <= 1'b0;
            rr.o_uses_rt     <= 1'b0;
            rr.o_uses_rw     <= 1'b0;
            rr.o_rs_phys     <= '0;
            rr.o_rt_phys     <= '0;
            rr.o_rw_phys     <= '0;
            rr.o_old_rw_phys <= '0;
        end else if (fire) begin
            rr.o_valid       <= 1'b1;
            rr.o_uses_rs     <= rr.i_uses_rs;
            rr.o_uses_rt     <= rr.i_uses_rt;
            rr.o_uses_rw     <= rr.i_uses_rw;
            rr.o_rs_phys     <= rr.i_uses_rs ? rmt[rr.i_rs_addr] : '0;
            rr.o_rt_phys     <= rr.i_uses_rt ? rmt[rr.i_rt_addr] : '0;
            rr.o_rw_phys     <= alloc ? alloc_phys : '0;
            rr.o_old_rw_phys <= alloc ? rmt[rr.i_rw_addr] : '0;
        end else if (rr.i_ready) begin
            rr.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_rename.sv
// tb_reg_rename: directed and randomized checks of reg_rename against a queue-based model.
module tb_reg_rename;
    import reg_rename_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_rename_if rr();
    reg_rename dut (.clk(clk), .rst_n(rst_n), .rr(rr));

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    int m_rmt [32];
    int m_free [$];
    int owed [$];
    bit m_valid, m_urs, m_urt, m_urw;
    int m_rs, m_rt, m_rw, m_old;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (!m_valid || rr.i_ready) && m_free.size() != 0;
    endfunction

    // Model: the map is an int array, the free list a queue popped at the front and pushed at the back.
    always @(posedge clk) begin
        bit rdy;
        bit fire;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rmt[i] = i;
            m_free.delete();
            for (int p = 32; p < 64; p++) m_free.push_back(p);
            m_valid = 0; m_urs = 0; m_urt = 0; m_urw = 0;
            m_rs = 0; m_rt = 0; m_rw = 0; m_old = 0;
        end else begin
            rdy  = (!m_valid || rr.i_ready) && m_free.size() != 0;
            fire = rr.i_valid && rdy;
            if (fire) begin
                m_valid = 1;
                m_urs = rr.i_uses_rs; m_urt = rr.i_uses_rt; m_urw = rr.i_uses_rw;
                m_rs = rr.i_uses_rs ? m_rmt[rr.i_rs_addr] : 0;
                m_rt = rr.i_uses_rt ? m_rmt[rr.i_rt_addr] : 0;
                if (rr.i_uses_rw && rr.i_rw_addr != 0) begin
                    m_rw  = m_free.pop_front();
                    m_old = m_rmt[rr.i_rw_addr];
                    m_rmt[rr.i_rw_addr] = m_rw;
                end else begin
                    m_rw = 0; m_old = 0;
                end
            end else if (rr.i_ready) begin
                m_valid = 0;
            end
            if (rr.i_commit_free && rr.i_commit_phys != 0 && m_free.size() < 32)
                m_free.push_back(int'(rr.i_commit_phys));
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("o_valid", rr.o_valid, m_valid);
            check("o_ready", rr.o_ready, m_ready());
            check("o_free_count", rr.o_free_count, m_free.size());
            if (m_valid) begin
                check("o_uses_rs", rr.o_uses_rs, m_urs);
                check("o_uses_rt", rr.o_uses_rt, m_urt);
                check("o_uses_rw", rr.o_uses_rw, m_urw);
                check("o_rs_phys", rr.o_rs_phys, m_rs);
                check("o_rt_phys", rr.o_rt_phys, m_rt);
                check("o_rw_phys", rr.o_rw_phys, m_rw);
                check("o_old_rw_phys", rr.o_old_rw_phys, m_old);
            end
        end
    end

    // Registers legal to free: nonzero, not free, not currently mapped.
    function automatic void calc_owed();
        owed.delete();
        for (int p = 1; p < 64; p++) begin
            bit used = 0;
            foreach (m_free[k]) if (m_free[k] == p) used = 1;
            for (int a = 1; a < 32; a++) if (m_rmt[a] == p) used = 1;
            if (!used) owed.push_back(p);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit urs, input int rs, input bit urt, input int rt,
                         input bit urw, input int rw, input bit cf = 0, input int cp = 0);
        rr.i_valid = 1'b1;
        rr.i_uses_rs = urs; rr.i_rs_addr = arch_reg_t'(rs);
        rr.i_uses_rt = urt; rr.i_rt_addr = arch_reg_t'(rt);
        rr.i_uses_rw = urw; rr.i_rw_addr = arch_reg_t'(rw);
        rr.i_commit_free = cf; rr.i_commit_phys = phys_reg_t'(cp);
        tick();
        rr.i_valid = 1'b0;
        rr.i_commit_free = 1'b0;
    endtask

    task automatic free_reg(input int p);
        rr.i_commit_free = 1'b1;
        rr.i_commit_phys = phys_reg_t'(p);
        tick();
        rr.i_commit_free = 1'b0;
    endtask

    initial begin
        rr.i_valid = 0; rr.i_ready = 1;
        rr.i_uses_rs = 0; rr.i_rs_addr = '0;
        rr.i_uses_rt = 0; rr.i_rt_addr = '0;
        rr.i_uses_rw = 0; rr.i_rw_addr = '0;
        rr.i_commit_free = 0; rr.i_commit_phys = '0;
        tick();
        cmp_on = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", rr.o_valid, 0);
        check("rst_count", rr.o_free_count, 32);
        check("rst_ready", rr.o_ready, 1);
        check("rst_rw_phys", rr.o_rw_phys, 0);

        issue(1, 1, 1, 2, 1, 3);
        @(negedge clk);
        check("basic_rs", rr.o_rs_phys, 1);
        check("basic_rt", rr.o_rt_phys, 2);
        check("basic_rw", rr.o_rw_phys, 32);
        check("basic_old", rr.o_old_rw_phys, 3);
        check("basic_count", rr.o_free_count, 31);

        issue(1, 3, 0, 0, 1, 3);
        @(negedge clk);
        check("rename2_rs", rr.o_rs_phys, 32);
        check("rename2_rw", rr.o_rw_phys, 33);
        check("rename2_old", rr.o_old_rw_phys, 32);

        issue(0, 7, 0, 0, 1, 0);
        @(negedge clk);
        check("r0_rs", rr.o_rs_phys, 0);
        check("r0_rw", rr.o_rw_phys, 0);
        check("r0_old", rr.o_old_rw_phys, 0);
        check("r0_count", rr.o_free_count, 30);

        issue(0, 0, 0, 0, 1, 5);
        repeat (29) issue(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        check("exhaust_count", rr.o_free_count, 0);
        check("exhaust_ready", rr.o_ready, 0);
        check("exhaust_last_rw", rr.o_rw_phys, 63);

        free_reg(5);
        @(negedge clk);
        check("refill_count", rr.o_free_count, 1);
        check("refill_ready", rr.o_ready, 1);

        issue(0, 0, 0, 0, 1, 2, 1, 40);
        @(negedge clk);
        check("simul_rw", rr.o_rw_phys, 5);
        check("simul_count", rr.o_free_count, 1);

        issue(0, 0, 0, 0, 1, 4);
        @(negedge clk);
        check("after_simul_rw", rr.o_rw_phys, 40);
        check("after_simul_count", rr.o_free_count, 0);

        free_reg(1);
        free_reg(35);
        issue(1, 4, 0, 0, 1, 6);
        @(negedge clk);
        check("bp_first_rw", rr.o_rw_phys, 1);
        check("bp_first_rs", rr.o_rs_phys, 40);

        rr.i_ready = 1'b0;
        rr.i_valid = 1'b1;
        rr.i_uses_rw = 1'b1; rr.i_rw_addr = arch_reg_t'(7);
        repeat (3) begin
            tick();
            @(negedge clk);
            check("hold_valid", rr.o_valid, 1);
            check("hold_rw", rr.o_rw_phys, 1);
            check("hold_count", rr.o_free_count, 1);
            check("hold_ready", rr.o_ready, 0);
        end
        rr.i_ready = 1'b1;
        tick();
        rr.i_valid = 1'b0;
        @(negedge clk);
        check("bp_release_rw", rr.o_rw_phys, 35);
        check("bp_release_count", rr.o_free_count, 0);

        for (int n = 0; n < 1500; n++) begin
            calc_owed();
            rr.i_valid = ($urandom % 4) != 0;
            rr.i_ready = ($urandom % 4) != 0;
            rr.i_uses_rs = $urandom % 2; rr.i_rs_addr = arch_reg_t'($urandom);
            rr.i_uses_rt = $urandom % 2; rr.i_rt_addr = arch_reg_t'($urandom);
            rr.i_uses_rw = ($urandom % 4) != 0; rr.i_rw_addr = arch_reg_t'($urandom);
            rr.i_commit_free = 1'b0;
            if (owed.size() > 0 && ($urandom % 3) != 0) begin
                int idx = $urandom_range(owed.size() - 1);
                rr.i_commit_free = 1'b1;
                rr.i_commit_phys = phys_reg_t'(owed[idx]);
            end
            tick();
        end

        rr.i_valid = 1'b0;
        rr.i_commit_free = 1'b0;
        rr.i_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_valid", rr.o_valid, 0);
        check("rerst_count", rr.o_free_count, 32);
        issue(1, 9, 0, 0, 1, 3);
        @(negedge clk);
        check("rerst_rs", rr.o_rs_phys, 9);
        check("rerst_rw", rr.o_rw_phys, 32);
        check("rerst_old", rr.o_old_rw_phys, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
